riscv_regfile: RTL and testbench



---
 rtl/riscv_regfile.sv | 87 ++++++++
 tb/tb_riscv_regfile.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/riscv_regfile.sv
// RV32I integer register file: 32 x XLEN storage, one synchronous write port,
// two combinational read ports, x0 hardwired to zero.
// Optional write-first bypass on the read ports: define RISCV_REGFILE_BYPASS_EN.
// Without it, reads return stored contents only (read-first); the pipeline forwards externally.
// Data width is taken from `XLEN (defaults to 32 when not provided by the build).

`ifndef XLEN
`define XLEN 32
`endif

module riscv_regfile #(
  parameter logic [`XLEN-1:0] REGFILE_INIT = `XLEN'h0,
  parameter int unsigned      NREG         = 32,
  parameter int unsigned      AWIDTH       = 5
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  output logic [`XLEN-1:0]  o_rs1_data,
  output logic [`XLEN-1:0]  o_rs2_data,
  input  logic [AWIDTH-1:0] i_rs1_addr,
  input  logic [AWIDTH-1:0] i_rs2_addr,
  input  logic [AWIDTH-1:0] i_rd_addr,
  input  logic [`XLEN-1:0]  i_rd_data,
  input  logic              i_rd_we
);

  localparam int unsigned XLEN_W = `XLEN;

  // Entry 0 is held at zero and never written; reads of address 0 are also masked.
  logic [XLEN_W-1:0] regs [NREG];

  logic rd_valid;
  assign rd_valid = i_rd_we && (i_rd_addr != '0);

  // Storage: async reset loads REGFILE_INIT into x1..x31, then enabled writes to non-zero addresses.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      regs[0] <= '0;
      for (int i = 1; i < int'(NREG); i++) begin
        regs[i] <= REGFILE_INIT;
      end
    end else if (rd_valid) begin
      regs[i_rd_addr] <= i_rd_data;
    end
  end

`ifdef RISCV_REGFILE_BYPASS_EN
  logic byp1;
  logic byp2;

  // Write-first bypass: a live write to the addressed register shows through in the same cycle.
  always_comb begin
    byp1 = 1'b0;
    byp2 = 1'b0;
    if (i_rstn && rd_valid) begin
      byp1 = (i_rs1_addr == i_rd_addr);
      byp2 = (i_rs2_addr == i_rd_addr);
    end
  end
`else
  logic byp1;
  logic byp2;

  // Read-first build: stored contents only.
  always_comb begin
    byp1 = 1'b0;
    byp2 = 1'b0;
  end
`endif

  // Read port 1: zero for x0, bypassed write data when enabled, else stored value.
  always_comb begin
    o_rs1_data = '0;
    if (i_rs1_addr != '0) begin
      o_rs1_data = byp1 ? i_rd_data : regs[i_rs1_addr];
    end
  end

  // Read port 2: same rules as port 1, fully independent.
  always_comb begin
    o_rs2_data = '0;
    if (i_rs2_addr != '0) begin
      o_rs2_data = byp2 ? i_rd_data : regs[i_rs2_addr];
    end
  end

endmodule

// File: tb/tb_riscv_regfile.sv
// Self-checking bench for riscv_regfile: directed cases plus a random regression
// against an array-based reference model. Honours RISCV_REGFILE_BYPASS_EN when defined.

module tb_riscv_regfile;

  localparam logic [31:0] INIT = 32'h0A0A0A0A;
`ifdef RISCV_REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] rs1_data, rs2_data;
  logic [4:0]  rs1_addr, rs2_addr, rd_addr;
  logic [31:0] rd_data;
  logic        rd_we;

  logic [31:0] mdl [32];
  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  riscv_regfile #(.REGFILE_INIT(INIT)) dut (
    .i_clk      (clk),
    .i_rstn     (rstn),
    .o_rs1_data (rs1_data),
    .o_rs2_data (rs2_data),
    .i_rs1_addr (rs1_addr),
    .i_rs2_addr (rs2_addr),
    .i_rd_addr  (rd_addr),
    .i_rd_data  (rd_data),
    .i_rd_we    (rd_we)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Expected read value from the architectural rules.
  function automatic logic [31:0] exp_rd(input logic [4:0] a);
    if (a == 5'd0) return 32'h0;
    if (BYP && rstn && rd_we && rd_addr != 5'd0 && rd_addr == a) return rd_data;
    return mdl[a];
  endfunction

  task automatic model_reset();
    mdl[0] = 32'h0;
    for (int i = 1; i < 32; i++) mdl[i] = INIT;
  endtask

  // Advance one rising edge, apply the write to the model, settle.
  task automatic step();
    @(posedge clk);
    if (rstn && rd_we && rd_addr != 5'd0) mdl[rd_addr] = rd_data;
    #1;
  endtask

  task automatic drive(input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] wa,
                       input logic [31:0] wd, input logic we);
    @(negedge clk);
    rs1_addr = a1; rs2_addr = a2; rd_addr = wa; rd_data = wd; rd_we = we;
    #1;
  endtask

  task automatic sweep(input string tag);
    rd_we = 1'b0;
    for (int a = 0; a < 32; a++) begin
      rs1_addr = 5'(a);
      rs2_addr = 5'(31 - a);
      #1;
      check($sformatf("%s_rs1_x%0d", tag, a), rs1_data, exp_rd(rs1_addr));
      check($sformatf("%s_rs2_x%0d", tag, 31 - a), rs2_data, exp_rd(rs2_addr));
    end
  endtask

  initial begin
    rstn = 1'b0;
    rs1_addr = 5'd5; rs2_addr = 5'd0; rd_addr = 5'd5; rd_data = 32'hFFFF0000; rd_we = 1'b1;
    model_reset();

    // Reset held for 4 cycles with a write presented; it must be ignored.
    repeat (4) @(posedge clk);
    #1;
    check("reset_rs1_x5", rs1_data, INIT);
    check("reset_rs2_x0", rs2_data, 32'h0);
    @(negedge clk);
    rstn = 1'b1;
    rd_we = 1'b0;
    #1;
    sweep("post_reset");

    // Write x5, read on both ports next cycle; then a disabled write must not land.
    drive(5'd5, 5'd5, 5'd5, 32'hDEADBEEF, 1'b1);
    step();
    check("x5_rs1", rs1_data, 32'hDEADBEEF);
    check("x5_rs2", rs2_data, 32'hDEADBEEF);
    drive(5'd5, 5'd5, 5'd5, 32'h12345678, 1'b0);
    step();
    check("x5_hold_rs1", rs1_data, 32'hDEADBEEF);
    check("x5_hold_rs2", rs2_data, 32'hDEADBEEF);

    // Write to x0 is dropped and touches nothing else.
    drive(5'd0, 5'd0, 5'd0, 32'hFFFFFFFF, 1'b1);
    check("x0_pre", rs1_data, 32'h0);
    step();
    check("x0_post", rs1_data, 32'h0);
    sweep("after_x0");

    // Same-cycle read/write of x7.
    drive(5'd7, 5'd7, 5'd7, 32'h11111111, 1'b1);
    step();
    drive(5'd7, 5'd7, 5'd7, 32'h22222222, 1'b1);
    check("rw_same_pre_rs1", rs1_data, BYP ? 32'h22222222 : 32'h11111111);
    check("rw_same_pre_rs2", rs2_data, BYP ? 32'h22222222 : 32'h11111111);
    step();
    check("rw_same_post_rs1", rs1_data, 32'h22222222);

    // Asynchronous reset between edges discards a pending write.
    drive(5'd9, 5'd9, 5'd9, 32'hCAFEF00D, 1'b1);
    step();
    check("x9_written", rs1_data, 32'hCAFEF00D);
    drive(5'd9, 5'd7, 5'd9, 32'h55555555, 1'b1);
    #1;
    rstn = 1'b0;
    model_reset();
    #1;
    check("async_rst_rs1_x9", rs1_data, INIT);
    check("async_rst_rs2_x7", rs2_data, INIT);
    step();
    check("rst_write_lost", rs1_data, INIT);
    // First write after release lands on the first rising edge.
    @(negedge clk);
    rstn = 1'b1;
    rd_data = 32'hA5A5A5A5;
    #1;
    check("release_pre_edge", rs1_data, BYP ? 32'hA5A5A5A5 : INIT);
    step();
    check("release_first_write", rs1_data, 32'hA5A5A5A5);

    // Random regression against the reference model.
    for (int n = 0; n < 100; n++) begin
      drive(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
            5'($urandom_range(0, 31)), $urandom, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) rd_addr = rs1_addr;
      #1;
      check($sformatf("rnd%0d_pre_rs1", n), rs1_data, exp_rd(rs1_addr));
      check($sformatf("rnd%0d_pre_rs2", n), rs2_data, exp_rd(rs2_addr));
      step();
      check($sformatf("rnd%0d_post_rs1", n), rs1_data, exp_rd(rs1_addr));
      check($sformatf("rnd%0d_post_rs2", n), rs2_data, exp_rd(rs2_addr));
    end
    @(negedge clk);
    sweep("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
